// File: rtl/soc_periph_demux.sv
// rtl/soc_periph_demux.sv - address-decoding request/response demux with in-order tracking FIFO
module soc_periph_demux #(
    parameter int unsigned          NumSlaves = 10,
    parameter int unsigned          AddrWidth = 64,
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          MaxTrans  = 4,
    parameter logic [DataWidth-1:0] ErrData   = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic                           req_we_i,
    input  logic [DataWidth-1:0]           req_wdata_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DataWidth-1:0]           rsp_rdata_o,
    output logic                           rsp_err_o,
    output logic [NumSlaves-1:0]           slv_req_valid_o,
    input  logic [NumSlaves-1:0]           slv_req_ready_i,
    output logic [AddrWidth-1:0]           slv_addr_o,
    output logic                           slv_we_o,
    output logic [DataWidth-1:0]           slv_wdata_o,
    input  logic [NumSlaves-1:0]           slv_rsp_valid_i,
    output logic [NumSlaves-1:0]           slv_rsp_ready_o,
    input  logic [NumSlaves*DataWidth-1:0] slv_rsp_rdata_i,
    input  logic [NumSlaves-1:0]           slv_rsp_err_i
);

    localparam int unsigned PtrW = $clog2(MaxTrans);
    localparam int unsigned IdxW = 4;

    // ariane_soc address map, indexed by axi_slaves_t
    function automatic logic [63:0] slv_base(input int k);
        case (k)
            0:       slv_base = 64'h8000_0000;
            1:       slv_base = 64'h4000_0000;
            2:       slv_base = 64'h3000_0000;
            3:       slv_base = 64'h2000_0000;
            4:       slv_base = 64'h1800_0000;
            5:       slv_base = 64'h1000_0000;
            6:       slv_base = 64'h0C00_0000;
            7:       slv_base = 64'h0200_0000;
            8:       slv_base = 64'h0001_0000;
            default: slv_base = 64'h0000_0000;
        endcase
    endfunction

    function automatic logic [63:0] slv_len(input int k);
        case (k)
            0:       slv_len = 64'h4000_0000;
            1:       slv_len = 64'h0000_1000;
            2:       slv_len = 64'h0001_0000;
            3:       slv_len = 64'h0080_0000;
            4:       slv_len = 64'h0000_1000;
            5:       slv_len = 64'h0000_1000;
            6:       slv_len = 64'h03FF_FFFF;
            7:       slv_len = 64'h000C_0000;
            8:       slv_len = 64'h0001_0000;
            default: slv_len = 64'h0000_1000;
        endcase
    endfunction

    logic [64:0]      addr_ext;
    logic [IdxW-1:0]  hit_idx;
    logic             derr;
    logic             sel_ready;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic [IdxW:0]    fifo_q [MaxTrans];
    logic             fifo_full, fifo_empty, push, pop;
    logic [IdxW:0]    head;
    logic [IdxW-1:0]  head_idx;
    logic             head_derr;

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        addr_ext = {{(65-AddrWidth){1'b0}}, req_addr_i};
        hit_idx  = '0;
        derr     = 1'b1;
        for (int k = int'(NumSlaves) - 1; k >= 0; k--) begin
            if (addr_ext >= {1'b0, slv_base(k)} &&
                addr_ext < ({1'b0, slv_base(k)} + {1'b0, slv_len(k)})) begin
                hit_idx = IdxW'(k);
                derr    = 1'b0;
            end
        end
    end

    assign fifo_full  = cnt_q[PtrW];
    assign fifo_empty = (cnt_q == '0);

    assign slv_addr_o  = req_addr_i;
    assign slv_we_o    = req_we_i;
    assign slv_wdata_o = req_wdata_i;

    always_comb begin
        slv_req_valid_o = '0;
        sel_ready       = 1'b0;
        for (int k = 0; k < int'(NumSlaves); k++) begin
            if (!derr && hit_idx == IdxW'(k)) begin
                slv_req_valid_o[k] = req_valid_i & ~fifo_full;
                sel_ready          = slv_req_ready_i[k];
            end
        end
        req_ready_o = ~fifo_full & (derr | sel_ready);
    end

    assign head      = fifo_q[rd_ptr_q];
    assign head_idx  = head[IdxW:1];
    assign head_derr = head[0];

    always_comb begin
        rsp_valid_o     = 1'b0;
        rsp_rdata_o     = '0;
        rsp_err_o       = 1'b0;
        slv_rsp_ready_o = '0;
        if (!fifo_empty) begin
            if (head_derr) begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = ErrData;
                rsp_err_o   = 1'b1;
            end else begin
                for (int k = 0; k < int'(NumSlaves); k++) begin
                    if (head_idx == IdxW'(k)) begin
                        rsp_valid_o        = slv_rsp_valid_i[k];
                        rsp_rdata_o        = slv_rsp_rdata_i[k*DataWidth +: DataWidth];
                        rsp_err_o          = slv_rsp_err_i[k];
                        slv_rsp_ready_o[k] = rsp_ready_i;
                    end
                end
            end
        end
    end

    assign push = req_valid_i & req_ready_o;
    assign pop  = rsp_valid_o & rsp_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        cnt_d    = cnt_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage needs no reset: the count gates every read of it
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {hit_idx, derr};
        end
    end

endmodule

// File: doc/soc_periph_demux.md
Name: soc_periph_demux

Overview:
- Address-decoding request/response demultiplexer between the core-side peripheral port and the SoC slaves (DRAM, GPIO, Ethernet, SPI, Timer, UART, PLIC, CLINT, ROM, Debug).
- Uses the ariane_soc address map (axi_slaves_t indices, soc_bus_start_t bases, *Length constants) to route each request.
- Tracks outstanding transactions so responses return in order.
- Terminates unmapped accesses locally with an error response.

Parameters:
- NumSlaves, ariane_soc::NB_PERIPHERALS (10): number of downstream slaves; slave index equals the axi_slaves_t value.
- AddrWidth, 64: request address width.
- DataWidth, 64: data width.
- MaxTrans, 4: outstanding-transaction FIFO depth; must be a power of two and at least 2.
- ErrData, 64'hDEAD_BEEF_DEAD_BEEF: read data returned on a decode error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request accepted.
- req_addr_i  in  AddrWidth  request address.
- req_we_i  in  1  write enable.
- req_wdata_i  in  DataWidth  write data.
- rsp_valid_o  out  1  upstream response valid.
- rsp_ready_i  in  1  upstream response accepted.
- rsp_rdata_o  out  DataWidth  response read data.
- rsp_err_o  out  1  response error (decode error or slave error).
- slv_req_valid_o  out  NumSlaves  one-hot request valid to slaves.
- slv_req_ready_i  in  NumSlaves  per-slave request ready.
- slv_addr_o  out  AddrWidth  broadcast address.
- slv_we_o  out  1  broadcast write enable.
- slv_wdata_o  out  DataWidth  broadcast write data.
- slv_rsp_valid_i  in  NumSlaves  per-slave response valid.
- slv_rsp_ready_o  out  NumSlaves  one-hot response ready.
- slv_rsp_rdata_i  in  NumSlaves*DataWidth  packed per-slave read data; slave k occupies bits [k*DataWidth +: DataWidth].
- slv_rsp_err_i  in  NumSlaves  per-slave response error.

Behaviour:
- Decode (combinational):
  - Slave k hits when Base_k <= addr < Base_k + Length_k, compared with a 65-bit sum so there is no overflow.
  - If more than one slave hits, the lowest index wins.
  - If no slave hits, the request is a decode error (derr).
- Request path (zero latency):
  - slv_addr_o, slv_we_o and slv_wdata_o are always equal to the request inputs.
  - slv_req_valid_o[k] = req_valid_i & hit_k & !fifo_full.
  - For a mapped address, req_ready_o = !fifo_full & slv_req_ready_i[k].
  - For derr, req_ready_o = !fifo_full, and no slave valid is raised.
- Tracking FIFO:
  - Depth MaxTrans. Each entry holds {slave idx (4 bits), derr bit}.
  - Push occurs on the upstream handshake (req_valid_i & req_ready_o). Pop occurs on the upstream response handshake.
  - Read and write pointers are log2(MaxTrans) bits and wrap naturally. A count register of log2(MaxTrans)+1 bits distinguishes full from empty.
  - Full blocks a push even when a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged.
- Response path (head entry h):
  - Empty FIFO: rsp_valid_o = 0 and slv_rsp_ready_o = 0.
  - Head is derr: rsp_valid_o = 1, rsp_rdata_o = ErrData, rsp_err_o = 1. The earliest assertion is the cycle after acceptance.
  - Head is mapped: rsp_valid_o = slv_rsp_valid_i[h]; rdata and err come from slave h; slv_rsp_ready_o[h] = rsp_ready_i; all other bits are 0.
  - Responses from non-head slaves are held by ready = 0, which guarantees in-order return.
- Request and response handshakes may complete in the same cycle, including for the same slave.
- Reset:
  - Pointers and count clear immediately, so the FIFO is empty.
  - rsp_valid_o and all slv_rsp_ready_o go to 0.
  - req_ready_o, slv_req_valid_o and the broadcast outputs follow the inputs combinationally.
  - In-flight transactions are dropped; slaves are reset by the same rst_ni.

Test Plan:
- Single read to 0x1000_0004 (UART, idx 5) → slv_req_valid_o = 10'b00_0010_0000 in the same cycle. UART responds rdata 0x41 → rsp_rdata_o = 0x41, rsp_err_o = 0.
- Read to 0x020C_0000 (one past the CLINT end) → no slave valid; req_ready_o = 1; next cycle rsp_valid_o = 1, rsp_rdata_o = 0xDEAD_BEEF_DEAD_BEEF, rsp_err_o = 1.
- DRAM boundary: 0xBFFF_FFF8 routes to idx 0; 0xC000_0000 gives a decode error (1 GiB DRAMLength).
- Ordering: request to DRAM, then to Timer. Timer responds first → slv_rsp_ready_o[4] = 0 until the DRAM response is popped; upstream sees the DRAM response, then the Timer response.
- Full: 4 outstanding DRAM reads with no responses → 5th request sees req_ready_o = 0 and slv_req_valid_o = 0. After one response pops, the 5th request is accepted the following cycle.
- Reset with 3 outstanding: assert rst_ni = 0 mid-burst → rsp_valid_o = 0 immediately. After release, a new UART request followed by its response completes normally with no stale responses.
